condition_handler: RTL and testbench



---
 rtl/condition_handler.sv | 82 ++++++++
 tb/tb_condition_handler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/condition_handler.sv
// Branch-condition evaluator: registered taken (J) and delay-slot nullify (n_out) decision.
// Optional feature macro: CH_NULLIFY_EN drives n_out; when it is undefined, n_out stays 0.
module condition_handler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BL,
  input  logic       COMB,
  input  logic       COMB_TF,
  input  logic       n_in,
  input  logic [2:0] C,
  input  logic [3:0] ACC,
  output logic       J,
  output logic       n_out
);

  // Condition codes, named after the assembler mnemonics
  typedef enum logic [2:0] {
    CondNever = 3'b000,
    CondEq    = 3'b001,
    CondLt    = 3'b010,
    CondLe    = 3'b011,
    CondLtu   = 3'b100,
    CondLeu   = 3'b101,
    CondSv    = 3'b110,
    CondOd    = 3'b111
  } cond_e;

  logic flag_z, flag_n, flag_c, flag_x;
  logic cond_true;
  logic j_nxt;
  logic n_nxt;

  assign flag_z = ACC[3];
  assign flag_n = ACC[2];
  assign flag_c = ACC[1];
  assign flag_x = ACC[0];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(C))
      CondNever: cond_true = 1'b0;
      CondEq:    cond_true = flag_z;
      CondLt:    cond_true = flag_n ^ flag_x;
      CondLe:    cond_true = (flag_n ^ flag_x) | flag_z;
      CondLtu:   cond_true = ~flag_c;
      CondLeu:   cond_true = ~flag_c | flag_z;
      CondSv:    cond_true = flag_x;
      CondOd:    cond_true = flag_x;
      default:   cond_true = 1'b0;
    endcase
  end

  // Priority chain keeps C/ACC out of the result when no branch is decoding,
  // so unknown flags cannot reach J.
  always_comb begin
    j_nxt = 1'b0;
    if (BL) begin
      j_nxt = 1'b1;
    end else if (COMB) begin
      j_nxt = cond_true ^ COMB_TF;
    end
  end

`ifdef CH_NULLIFY_EN
  assign n_nxt = n_in & j_nxt;
`else
  logic unused_n_in;
  assign unused_n_in = n_in;
  assign n_nxt       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      J     <= 1'b0;
      n_out <= 1'b0;
    end else begin
      J     <= j_nxt;
      n_out <= n_nxt;
    end
  end

endmodule

// File: tb/tb_condition_handler.sv
// Directed self-checking bench for condition_handler; honours CH_NULLIFY_EN for n_out expectations.
module tb_condition_handler;

  logic       clk;
  logic       rst_n;
  logic       BL, COMB, COMB_TF, n_in;
  logic [2:0] C;
  logic [3:0] ACC;
  logic       J, n_out;

  int unsigned num_checks;
  int unsigned num_errors;

`ifdef CH_NULLIFY_EN
  localparam logic NullEn = 1'b1;
`else
  localparam logic NullEn = 1'b0;
`endif

  condition_handler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .BL      (BL),
    .COMB    (COMB),
    .COMB_TF (COMB_TF),
    .n_in    (n_in),
    .C       (C),
    .ACC     (ACC),
    .J       (J),
    .n_out   (n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bl, input logic comb, input logic tf, input logic nin,
                       input logic [2:0] c, input logic [3:0] acc);
    BL = bl; COMB = comb; COMB_TF = tf; n_in = nin; C = c; ACC = acc;
  endtask

  // Sweep with ACC=0001: X=1, N=0, Z=0 and carry clear, so << and <<= are true too.
  logic [7:0] sweep_exp;

  initial begin
    num_checks = 0;
    num_errors = 0;
    sweep_exp  = 8'b1111_1100;  // bit i = expected J for C=i

    // 1. Reset holds outputs low even with a taken branch presented
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 4'b0000);
    step();
    check("rst1_j", J, 1'b0);
    check("rst1_n", n_out, 1'b0);
    step();
    check("rst2_j", J, 1'b0);
    check("rst2_n", n_out, 1'b0);
    rst_n = 1'b1;
    step();
    check("bl_j", J, 1'b1);
    check("bl_n", n_out, NullEn);

    // 2. Equal on Z, then inverted sense
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 4'b1000);
    step();
    check("eq_true", J, 1'b1);
    COMB_TF = 1'b1;
    step();
    check("eq_false", J, 1'b0);

    // 3. Less-than on N^X
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 4'b0100);
    step();
    check("lt_n", J, 1'b1);
    ACC = 4'b0101;
    step();
    check("lt_nx", J, 1'b0);

    // 4. Unsigned compares and never
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 4'b0010);
    step();
    check("ltu", J, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 4'b1010);
    step();
    check("leu", J, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'b1111);
    step();
    check("never", J, 1'b0);
    COMB_TF = 1'b1;
    step();
    check("never_inv", J, 1'b1);

    // 5. BL beats COMB; idle ignores unknown flags
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'b0000);
    step();
    check("bl_prio_j", J, 1'b1);
    check("bl_prio_n", n_out, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 4'bxxxx);
    step();
    check("idle_j", J, 1'b0);
    check("idle_n", n_out, 1'b0);

    // 6. Reset while a taken branch is in flight
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 4'b0000);
    step();
    check("flight_j", J, 1'b1);
    check("flight_n", n_out, NullEn);
    rst_n = 1'b0;
    step();
    check("flight_rst_j", J, 1'b0);
    check("flight_rst_n", n_out, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'(i), 4'b0001);
      step();
      check($sformatf("sweep_j_c%0d", i), J, sweep_exp[i]);
      check($sformatf("sweep_n_c%0d", i), n_out, sweep_exp[i] & NullEn);
    end

    // Taken branch without ,n never nullifies
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 4'b0000);
    step();
    check("no_n_j", J, 1'b1);
    check("no_n_n", n_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
